// File: rtl/ram_bist_ctrl.sv
// RAM built-in self test controller.
// Runs a two-pass march over the RAM: write PATTERN, read back, write
// ~PATTERN, read back. Read data is compared one cycle after each read
// strobe. Result fields report the mismatch count and the first failing
// address and data.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start, RAM strobes low, result fields held
// WR0   | write PATTERN to addresses 0..DEPTH-1
// RD0   | read addresses 0..DEPTH-1, expect PATTERN
// WR1   | write ~PATTERN to addresses 0..DEPTH-1
// RD1   | read addresses 0..DEPTH-1, expect ~PATTERN
// FLUSH | no RAM access, lets the last RD1 compare finish
module ram_bist_ctrl #(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DEPTH      = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'hAA
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH+1:0] err_cnt,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [DATA_WIDTH-1:0] err_data
);

    typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, FLUSH} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

    logic                    wr_en_q, rd_en_q, busy_q, done_q, pass_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, rd_addr_q, err_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q, err_data_q;
    logic [ADDR_WIDTH+1:0]   err_cnt_q, err_cnt_d;

    logic                    cmp_vld_q;
    logic [ADDR_WIDTH-1:0]   cmp_addr_q;
    logic [DATA_WIDTH-1:0]   cmp_exp_q;
    logic                    mismatch;
    logic                    wr_d, rd_d;

    // Next state and address counter; the counter wraps to 0 on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WR0;
                    cnt_d   = '0;
                end
            end
            WR0, RD0, WR1, RD1: begin
                if (cnt_q == LAST_ADDR) begin
                    cnt_d = '0;
                    case (state_q)
                        WR0:     state_d = RD0;
                        RD0:     state_d = WR1;
                        WR1:     state_d = RD1;
                        default: state_d = FLUSH;
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Compare of the read issued last cycle, with a saturating error count.
    always_comb begin
        mismatch  = cmp_vld_q && (rd_data != cmp_exp_q);
        err_cnt_d = err_cnt_q;
        if (mismatch && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    assign wr_d = (state_d == WR0) || (state_d == WR1);
    assign rd_d = (state_d == RD0) || (state_d == RD1);

    // FSM, registered RAM strobes, compare pipeline and result fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            err_data_q <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_addr_q <= '0;
            cmp_exp_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_d;
            wr_addr_q <= wr_d ? cnt_d : '0;
            wr_data_q <= (state_d == WR0) ? PATTERN :
                         (state_d == WR1) ? ~PATTERN : '0;
            rd_en_q   <= rd_d;
            rd_addr_q <= rd_d ? cnt_d : '0;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_q == FLUSH);

            // Expected value is tagged at issue time so the compare never looks at state.
            cmp_vld_q  <= rd_en_q;
            cmp_addr_q <= rd_addr_q;
            cmp_exp_q  <= (state_q == RD0) ? PATTERN : ~PATTERN;

            if ((state_q == IDLE) && start) begin
                pass_q     <= 1'b0;
                err_cnt_q  <= '0;
                err_addr_q <= '0;
                err_data_q <= '0;
            end else begin
                err_cnt_q <= err_cnt_d;
                if (mismatch && (err_cnt_q == '0)) begin
                    err_addr_q <= cmp_addr_q;
                    err_data_q <= rd_data;
                end
                if (state_q == FLUSH) begin
                    pass_q <= (err_cnt_d == '0);
                end
            end
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign rd_en    = rd_en_q;
    assign rd_addr  = rd_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;
    assign err_data = err_data_q;

endmodule

// File: doc/ram_bist_ctrl.md
RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, address width of the RAM port.
REQ-002 The block SHALL have parameter DEPTH, default 16, number of RAM words tested (2**ADDR_WIDTH).
REQ-003 The block SHALL have parameter DATA_WIDTH, default 8, RAM word width.
REQ-004 The block SHALL have parameter PATTERN, default 8'hAA, background data for the first pass; the second pass uses ~PATTERN.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port start, input, 1, single-cycle test request.
REQ-008 The block SHALL have port wr_en, output, 1, RAM write strobe.
REQ-009 The block SHALL have port wr_addr, output, ADDR_WIDTH, RAM write address.
REQ-010 The block SHALL have port wr_data, output, DATA_WIDTH, RAM write data.
REQ-011 The block SHALL have port rd_en, output, 1, RAM read strobe.
REQ-012 The block SHALL have port rd_addr, output, ADDR_WIDTH, RAM read address.
REQ-013 The block SHALL have port rd_data, input, DATA_WIDTH, RAM read data, valid exactly one cycle after the rd_en cycle.
REQ-014 The block SHALL have port busy, output, 1, high while a test is in progress.
REQ-015 The block SHALL have port done, output, 1, one-cycle pulse marking test completion.
REQ-016 The block SHALL have port pass, output, 1, test result, meaningful from done onward.
REQ-017 The block SHALL have port err_cnt, output, ADDR_WIDTH+2, count of mismatching reads.
REQ-018 The block SHALL have port err_addr, output, ADDR_WIDTH, address of the first mismatch.
REQ-019 The block SHALL have port err_data, output, DATA_WIDTH, rd_data captured at the first mismatch.

Function
REQ-020 The FSM SHALL have states IDLE, WR0, RD0, WR1, RD1, FLUSH; transitions: IDLE->WR0 on start, each WR/RD state->next after DEPTH cycles, RD1->FLUSH, FLUSH->IDLE after one cycle.
REQ-021 An internal address counter SHALL run 0..DEPTH-1 ascending, one address per cycle, in each of WR0/RD0/WR1/RD1, and SHALL wrap to 0 on each state change.
REQ-022 In WR0 the block SHALL drive wr_en=1, wr_addr=counter, wr_data=PATTERN; in WR1 the same with wr_data=~PATTERN.
REQ-023 In RD0/RD1 the block SHALL drive rd_en=1, rd_addr=counter; wr_en and rd_en SHALL never be high in the same cycle.
REQ-024 Each read SHALL be compared one cycle later against the expected value of its pass, using a delayed valid/address/expected pipeline that is independent of the current state.
REQ-025 On mismatch, err_cnt SHALL increment by 1, saturating at all-ones; on the first mismatch of a test, err_addr and err_data SHALL be captured and then held.
REQ-026 FLUSH SHALL exist only to complete the final RD1 comparison; the compare of RD0's last read SHALL complete during the first WR1 cycle.
REQ-027 busy SHALL be high from the cycle after start is sampled through FLUSH inclusive.
REQ-028 done SHALL pulse for exactly one cycle, 4*DEPTH+2 cycles after the cycle in which start is sampled (66 at defaults).
REQ-029 pass SHALL be set with done to (err_cnt==0) and held until the next accepted start.
REQ-030 start while busy SHALL be ignored; start in IDLE SHALL clear pass, err_cnt, err_addr, err_data and begin a new test.
REQ-031 In IDLE all RAM strobes SHALL be 0; address/data outputs SHALL be 0 when their strobe is 0.

Reset
REQ-032 rst SHALL force state IDLE, counter 0, compare pipeline invalid, and every output (wr_en, wr_addr, wr_data, rd_en, rd_addr, busy, done, pass, err_cnt, err_addr, err_data) to 0 on the next posedge.
REQ-033 rst asserted mid-test SHALL abort it with no further RAM accesses and no done pulse; rst has priority over start.

Verification
REQ-034 Fault-free RAM_D, start pulse -> 16 writes of 0xAA, 16 reads, 16 writes of 0x55, 16 reads, done at cycle 66, pass=1, err_cnt=0.
REQ-035 RAM with bit0 stuck-at-0 at addr 5 -> done at cycle 66, pass=0, err_cnt=1, err_addr=5, err_data=0x54.
REQ-036 RAM with addr 3 stuck at 0xFF -> err_cnt=2, err_addr=3, err_data=0xFF, pass=0.
REQ-037 rst asserted during WR1 (cycle 40) -> all outputs 0 next cycle, no wr_en/rd_en afterward, no done.
REQ-038 start re-pulsed at cycle 20 (busy) -> ignored, done still at cycle 66; second start after done -> err fields cleared, full test reruns.
